oled_fb_arbiter: RTL and testbench

Shares one single-port 128x128x16 framebuffer RAM between the SPI OLED scan core (read requester) and the camera pixel stream (write requester). Display reads have absolute priority and a fixed 3-cycle latency from the scan core's next-pixel strobe; camera writes are buffered in a small FIFO and drained into idle RAM cycles. The block sits between the camera capture logic, the block RAM and the OLED scan core's x/y/next_pixel/color port.

---
 rtl/oled_fb_pkg.sv | 21 ++
 rtl/oled_fb_wr_fifo.sv | 53 +++++
 rtl/oled_fb_arbiter.sv | 147 ++++++++++++++
 tb/tb_oled_fb_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_fb_pkg.sv
// Shared types for the OLED framebuffer arbiter:
// address width, FSM states and the camera write record.
package oled_fb_pkg;

    localparam int unsigned X_BITS     = 7;
    localparam int unsigned Y_BITS     = 7;
    localparam int unsigned ADDR_BITS  = X_BITS + Y_BITS;
    localparam int unsigned COLOR_BITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP
    } fb_state_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [COLOR_BITS-1:0] color;
    } fb_wr_t;

endpackage

// File: rtl/oled_fb_wr_fifo.sv
// Small synchronous FIFO buffering camera writes;
// ready is registered and already reflects a same-cycle pop.
module oled_fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = mem[rd_ptr];

    always_comb begin
        count_d = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_d;
            ready <= (count_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/oled_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads win with a fixed
// 3-cycle latency, camera writes drain through a FIFO into idle slots.
module oled_fb_arbiter
    import oled_fb_pkg::*;
#(
    parameter int c_x_bits     = 7,
    parameter int c_y_bits     = 7,
    parameter int c_color_bits = 16,
    parameter int c_fifo_depth = 4
) (
    input  logic                         clk,
    input  logic                         resn,
    input  logic [c_x_bits-1:0]          disp_x,
    input  logic [c_y_bits-1:0]          disp_y,
    input  logic                         disp_next,
    output logic [c_color_bits-1:0]      disp_color,
    input  logic                         cam_valid,
    output logic                         cam_ready,
    input  logic [c_x_bits-1:0]          cam_x,
    input  logic [c_y_bits-1:0]          cam_y,
    input  logic [c_color_bits-1:0]      cam_color,
    output logic [c_x_bits+c_y_bits-1:0] mem_addr,
    output logic                         mem_we,
    output logic [c_color_bits-1:0]      mem_wdata,
    input  logic [c_color_bits-1:0]      mem_rdata,
    output logic                         rd_overrun,
    output logic [15:0]                  wr_stall_cnt
);

    localparam int AW = c_x_bits + c_y_bits;
    localparam int EW = $bits(fb_wr_t);

    fb_state_t         state;
    fb_state_t         state_d;
    fb_wr_t            wr_in;
    fb_wr_t            wr_head;
    logic [EW-1:0]     head_bits;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              wr_ok;
    logic              pend_vld;
    logic              pend_d;
    logic [AW-1:0]     pend_addr;
    logic [AW-1:0]     cur_addr;
    logic [AW-1:0]     addr_d;
    logic              we_d;
    logic [c_color_bits-1:0] wdata_d;

    assign cur_addr = {disp_y, disp_x};
    assign wr_in    = '{addr: {cam_y, cam_x}, color: cam_color};
    assign wr_head  = fb_wr_t'(head_bits);
    assign push     = cam_valid && cam_ready && !fifo_full;

    oled_fb_wr_fifo #(
        .DEPTH (c_fifo_depth),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .resn  (resn),
        .push  (push),
        .pop   (pop),
        .wdata (wr_in),
        .rdata (head_bits),
        .empty (fifo_empty),
        .full  (fifo_full),
        .ready (cam_ready)
    );

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        addr_d  = mem_addr;
        we_d    = 1'b0;
        wdata_d = mem_wdata;
        pend_d  = pend_vld;
        wr_ok   = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (disp_next) begin
                    state_d = RD;
                    addr_d  = cur_addr;
                end else begin
                    wr_ok = !fifo_empty;
                end
            end
            RD: begin
                state_d = CAP;
                pend_d  = pend_vld | disp_next;
                wr_ok   = !fifo_empty;
            end
            CAP: begin
                pend_d = 1'b0;
                if (disp_next || pend_vld) begin
                    state_d = RD;
                    addr_d  = disp_next ? cur_addr : pend_addr;
                end else begin
                    state_d = IDLE;
                    wr_ok   = !fifo_empty;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr_ok) begin
            addr_d  = wr_head.addr;
            we_d    = 1'b1;
            wdata_d = wr_head.color;
            pop     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            disp_color <= '0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            rd_overrun <= 1'b0;
        end else begin
            mem_addr  <= addr_d;
            mem_we    <= we_d;
            mem_wdata <= wdata_d;
            pend_vld  <= pend_d;
            // latest coordinate always wins a re-issue
            if (disp_next) pend_addr <= cur_addr;
            if (state == CAP) disp_color <= mem_rdata;
            if (disp_next && state != IDLE) rd_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            wr_stall_cnt <= '0;
        end else if (cam_valid && !cam_ready && wr_stall_cnt != 16'hFFFF) begin
            wr_stall_cnt <= wr_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_oled_fb_arbiter.sv
// Directed bench for oled_fb_arbiter with a synchronous-read
// RAM model and hand-computed expectations.
module tb_oled_fb_arbiter;

    logic        clk = 1'b0;
    logic        resn = 1'b1;
    logic [6:0]  disp_x = '0;
    logic [6:0]  disp_y = '0;
    logic        disp_next = 1'b0;
    logic [15:0] disp_color;
    logic        cam_valid = 1'b0;
    logic        cam_ready;
    logic [6:0]  cam_x = '0;
    logic [6:0]  cam_y = '0;
    logic [15:0] cam_color = '0;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        rd_overrun;
    logic [15:0] wr_stall_cnt;

    logic [15:0] ram [0:16383];
    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oled_fb_arbiter dut (
        .clk          (clk),
        .resn         (resn),
        .disp_x       (disp_x),
        .disp_y       (disp_y),
        .disp_next    (disp_next),
        .disp_color   (disp_color),
        .cam_valid    (cam_valid),
        .cam_ready    (cam_ready),
        .cam_x        (cam_x),
        .cam_y        (cam_y),
        .cam_color    (cam_color),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .rd_overrun   (rd_overrun),
        .wr_stall_cnt (wr_stall_cnt)
    );

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [6:0]  x;
        logic [6:0]  y;
        logic [15:0] color;
        logic [13:0] addr;
    } rd_vec_t;

    rd_vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [13:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_disp_color"}, disp_color, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_cam_ready"}, cam_ready, 0);
        chk({tag, "_rd_overrun"}, rd_overrun, 0);
        chk({tag, "_stall_cnt"}, wr_stall_cnt, 0);
    endtask

    initial begin
        int bad;
        logic [15:0] exp_c;

        vecs[0] = '{7'd3,   7'd5,   16'hF800, 14'h0283};
        vecs[1] = '{7'd0,   7'd0,   16'h0001, 14'h0000};
        vecs[2] = '{7'd127, 7'd127, 16'hFFFF, 14'h3FFF};
        vecs[3] = '{7'd127, 7'd0,   16'h8001, 14'h007F};
        vecs[4] = '{7'd0,   7'd127, 16'h7FFE, 14'h3F80};

        #2 resn = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) preload(vecs[i].addr, vecs[i].color);
        preload(14'h0101, 16'h1234);
        preload(14'h0407, 16'hAAAA);
        preload(14'h0489, 16'h5555);
        for (int x = 0; x < 13; x++) preload(14'(12800 + x), 16'h0000);
        for (int x = 0; x < 6; x++) preload(14'(6400 + x), 16'hDEAD);

        chk_reset_vals("rst");
        resn = 1'b1;
        chk("rst_ready_low_at_release", cam_ready, 0);
        tick();
        chk("rst_ready_rise", cam_ready, 1);
        tick();
        tick();

        // single reads through the vector table
        for (int i = 0; i < 5; i++) begin
            disp_x    = vecs[i].x;
            disp_y    = vecs[i].y;
            disp_next = 1'b1;
            tick();
            disp_next = 1'b0;
            chk($sformatf("rd%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("rd%0d_we", i), mem_we, 0);
            tick();
            tick();
            chk($sformatf("rd%0d_color", i), disp_color, vecs[i].color);
            tick();
        end

        // collision: two writes queued when the read arrives
        cam_valid = 1'b1;
        cam_x = 7'd10; cam_y = 7'd20; cam_color = 16'h07E0;
        tick();
        disp_next = 1'b1; disp_x = 7'd1; disp_y = 7'd2;
        cam_x = 7'd1; cam_y = 7'd30; cam_color = 16'h2222;
        tick();
        disp_next = 1'b0;
        chk("col_c1_read_addr", mem_addr, 14'h0101);
        chk("col_c1_read_we", mem_we, 0);
        cam_x = 7'd2; cam_color = 16'h3333;
        tick();
        cam_x = 7'd3; cam_color = 16'h4444;
        chk("col_c2_we", mem_we, 1);
        chk("col_c2_addr", mem_addr, 14'h0A0A);
        chk("col_c2_wdata", mem_wdata, 16'h07E0);
        tick();
        cam_valid = 1'b0;
        disp_next = 1'b1; disp_x = 7'd10; disp_y = 7'd20;
        chk("col_c3_we", mem_we, 1);
        chk("col_c3_addr", mem_addr, 14'h0F01);
        chk("col_c3_color", disp_color, 16'h1234);
        tick();
        disp_next = 1'b0;
        chk("wtr_read_addr", mem_addr, 14'h0A0A);
        chk("wtr_read_we", mem_we, 0);
        tick();
        chk("col_w3_addr", mem_addr, 14'h0F02);
        chk("col_w3_wdata", mem_wdata, 16'h3333);
        tick();
        chk("col_w4_addr", mem_addr, 14'h0F03);
        chk("wtr_color", disp_color, 16'h07E0);
        tick();
        chk("col_idle_we", mem_we, 0);
        tick();
        tick();

        // overrun: back-to-back strobes, second coordinate wins
        chk("ovr_before", rd_overrun, 0);
        disp_next = 1'b1; disp_x = 7'd7; disp_y = 7'd8;
        tick();
        disp_x = 7'd9; disp_y = 7'd9;
        chk("ovr_c1_flag", rd_overrun, 0);
        tick();
        disp_next = 1'b0;
        chk("ovr_c2_flag", rd_overrun, 1);
        tick();
        chk("ovr_c3_addr", mem_addr, 14'h0489);
        chk("ovr_c3_color", disp_color, 16'hAAAA);
        tick();
        tick();
        chk("ovr_c5_color", disp_color, 16'h5555);
        tick();
        tick();

        // FIFO fills while continuous reads take half the port
        chk("fill_stall_start", wr_stall_cnt, 0);
        for (int c = 0; c < 19; c++) begin
            disp_next = (c < 10);
            disp_x    = 7'(c);
            disp_y    = 7'd60;
            cam_valid = (c < 13);
            cam_x     = 7'(c);
            cam_y     = 7'd100;
            cam_color = 16'(16'h1000 + c);
            if (c == 6) chk("fill_c6_ready", cam_ready, 1);
            if (c == 7) chk("fill_c7_ready", cam_ready, 0);
            if (c == 8) chk("fill_c8_ready", cam_ready, 1);
            if (c == 11) chk("fill_c11_ready", cam_ready, 0);
            tick();
        end
        disp_next = 1'b0;
        cam_valid = 1'b0;
        chk("fill_stall_cnt", wr_stall_cnt, 3);
        for (int x = 0; x < 13; x++) begin
            exp_c = (x == 7 || x == 9 || x == 11) ? 16'h0000 : 16'(16'h1000 + x);
            chk($sformatf("fill_ram_x%0d", x), ram[14'(12800 + x)], exp_c);
        end

        // reset with three entries queued and a write on the port
        for (int c = 0; c < 6; c++) begin
            disp_next = 1'b1;
            disp_x    = 7'(c);
            disp_y    = 7'd61;
            cam_valid = 1'b1;
            cam_x     = 7'(c);
            cam_y     = 7'd50;
            cam_color = 16'(16'hB000 + c);
            tick();
        end
        disp_next = 1'b0;
        cam_valid = 1'b0;
        chk("mid_we_before_rst", mem_we, 1);
        chk("mid_addr_before_rst", mem_addr, 14'(6400 + 2));
        resn = 1'b0;
        #1;
        chk_reset_vals("mid");
        tick();
        tick();
        resn = 1'b1;
        chk("mid_ready_low_at_release", cam_ready, 0);
        tick();
        chk("mid_ready_rise", cam_ready, 1);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (mem_we !== 1'b0) bad++;
            tick();
        end
        chk("mid_fifo_empty", bad, 0);
        chk("mid_ram_x0", ram[14'(6400)], 16'hB000);
        chk("mid_ram_x1", ram[14'(6401)], 16'hB001);
        for (int x = 2; x < 6; x++)
            chk($sformatf("mid_ram_x%0d", x), ram[14'(6400 + x)], 16'hDEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
